// File: rtl/ysyx_22040931_load_unit.sv
// ysyx_22040931_load_unit: load/writeback-path unit between execute and writeback.
// Issues one aligned 64-bit bus read per load, then extracts and sign/zero
// extends the addressed byte/half/word/dword. Non-load ops (MNO) pass the ALU
// result straight through. One op in flight at a time.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready, in_addr,
//   in_memrop, in_rd                    upstream op handshake and payload
//   rreq_valid/rreq_ready, rreq_addr    bus read request (dword aligned)
//   rresp_valid, rresp_data, rresp_err  bus read response
//   out_valid/out_ready, out_data,
//   out_rd, out_fault                   writeback handshake and result
//
// Build option: YSYX_22040931_LOAD_MISALIGN_EN
//   defined   -> misaligned loads complete with out_fault=1, out_data=0, no bus access
//   undefined -> low address bits below the access size are dropped (natural alignment)
module ysyx_22040931_load_unit #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [2:0]    in_memrop,
  input  logic [4:0]    in_rd,
  output logic          rreq_valid,
  input  logic          rreq_ready,
  output logic [AW-1:0] rreq_addr,
  input  logic          rresp_valid,
  input  logic [DW-1:0] rresp_data,
  input  logic          rresp_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_rd,
  output logic          out_fault
);

  localparam logic [2:0] MNO = 3'b000;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [2:0]    r_memrop, w_memrop_nxt;
  logic [4:0]    r_rd, w_rd_nxt;
  logic [DW-1:0] r_data, w_data_nxt;
  logic          r_fault, w_fault_nxt;
  logic          r_in_ready, r_rreq_valid, r_out_valid;

  // Address bits that must be zero for the access size of op.
  function automatic logic [2:0] f_lsb_mask(input logic [2:0] op);
    case (op)
      3'b010, 3'b110: f_lsb_mask = 3'b001;
      3'b011, 3'b111: f_lsb_mask = 3'b011;
      3'b100:         f_lsb_mask = 3'b111;
      default:        f_lsb_mask = 3'b000;
    endcase
  endfunction

  // Select the addressed lane of the returned dword and extend it.
  function automatic logic [63:0] f_extract(input logic [2:0] op, input logic [2:0] off,
                                            input logic [63:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[2:1], 4'b0000} +: 16];
    w = off[2] ? d[63:32] : d[31:0];
    case (op)
      3'b001:  f_extract = {{56{b[7]}}, b};
      3'b101:  f_extract = {56'd0, b};
      3'b010:  f_extract = {{48{h[15]}}, h};
      3'b110:  f_extract = {48'd0, h};
      3'b011:  f_extract = {{32{w[31]}}, w};
      3'b111:  f_extract = {32'd0, w};
      default: f_extract = d;
    endcase
  endfunction

  // Next-state and payload capture.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_memrop_nxt = r_memrop;
    w_rd_nxt     = r_rd;
    w_data_nxt   = r_data;
    w_fault_nxt  = r_fault;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_memrop_nxt = in_memrop;
          w_rd_nxt     = in_rd;
          if (in_memrop == MNO) begin
            w_addr_nxt  = in_addr;
            w_data_nxt  = DW'(in_addr);
            w_fault_nxt = 1'b0;
            w_state_nxt = S_DONE;
          end
`ifdef YSYX_22040931_LOAD_MISALIGN_EN
          else if (|(in_addr[2:0] & f_lsb_mask(in_memrop))) begin
            w_addr_nxt  = in_addr;
            w_data_nxt  = '0;
            w_fault_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
`endif
          else begin
            // Masking is a no-op for aligned loads; otherwise it forces natural alignment.
            w_addr_nxt  = in_addr & ~AW'(f_lsb_mask(in_memrop));
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (rreq_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rresp_valid) begin
          w_fault_nxt = rresp_err;
          w_data_nxt  = rresp_err ? '0 : DW'(f_extract(r_memrop, r_addr[2:0], 64'(rresp_data)));
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, payload and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_memrop     <= '0;
      r_rd         <= '0;
      r_data       <= '0;
      r_fault      <= 1'b0;
      r_in_ready   <= 1'b1;
      r_rreq_valid <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_memrop     <= w_memrop_nxt;
      r_rd         <= w_rd_nxt;
      r_data       <= w_data_nxt;
      r_fault      <= w_fault_nxt;
      r_in_ready   <= (w_state_nxt == S_IDLE);
      r_rreq_valid <= (w_state_nxt == S_REQ);
      r_out_valid  <= (w_state_nxt == S_DONE);
    end
  end

  assign in_ready   = r_in_ready;
  assign rreq_valid = r_rreq_valid;
  assign rreq_addr  = {r_addr[AW-1:3], 3'b000};
  assign out_valid  = r_out_valid;
  assign out_data   = r_data;
  assign out_rd     = r_rd;
  assign out_fault  = r_fault;

endmodule

// File: tb/tb_ysyx_22040931_load_unit.sv
// Testbench for ysyx_22040931_load_unit: directed and randomized loads checked
// against a reference model that works from access size, byte offset and
// shift/mask arithmetic. Honours YSYX_22040931_LOAD_MISALIGN_EN like the DUT.
module tb_ysyx_22040931_load_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [2:0]  in_memrop;
  logic [4:0]  in_rd;
  logic        rreq_valid;
  logic        rreq_ready;
  logic [63:0] rreq_addr;
  logic        rresp_valid;
  logic [63:0] rresp_data;
  logic        rresp_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  ysyx_22040931_load_unit #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_memrop(in_memrop), .in_rd(in_rd),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
    .rresp_valid(rresp_valid), .rresp_data(rresp_data), .rresp_err(rresp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_fault(out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: access size and signedness from the op, lane by shift and mask.
  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [2:0] op,
                                           input logic [63:0] data,
                                           output bit fault, output bit req);
    int sz;
    int off;
    logic [63:0] v;
    logic [63:0] m;
    fault = 1'b0;
    req   = 1'b1;
    case (op)
      3'd0:       begin req = 1'b0; return addr; end
      3'd1, 3'd5: sz = 1;
      3'd2, 3'd6: sz = 2;
      3'd3, 3'd7: sz = 4;
      default:    sz = 8;
    endcase
    off = int'(addr % 64'd8);
    if (off % sz != 0) begin
`ifdef YSYX_22040931_LOAD_MISALIGN_EN
      fault = 1'b1;
      req   = 1'b0;
      return 64'd0;
`else
      off = off - off % sz;
`endif
    end
    v = data >> (off * 8);
    if (sz < 8) begin
      m = (64'd1 << (sz * 8)) - 64'd1;
      v = v & m;
      if ((op inside {3'd1, 3'd2, 3'd3}) && v[sz*8-1]) v = v | ~m;
    end
    return v;
  endfunction

  // One complete op from IDLE back to IDLE with the requested stalls.
  task automatic do_op(input logic [63:0] addr, input logic [2:0] op, input logic [4:0] rd,
                       input logic [63:0] data, input bit err, input int req_stall,
                       input int wait_cyc, input int out_stall,
                       input bit use_want, input logic [63:0] want);
    logic [63:0] exp_d;
    logic [63:0] exp_a;
    bit exp_f;
    bit req;
    exp_d = ref_load(addr, op, data, exp_f, req);
    if (use_want) exp_d = want;
    if (req && err) begin exp_f = 1'b1; exp_d = 64'd0; end
    exp_a = addr & ~64'd7;

    check("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_addr = addr; in_memrop = op; in_rd = rd;
    @(posedge clk); #1;
    // Keep offering garbage; it must not be taken while busy.
    in_addr = {$urandom, $urandom}; in_memrop = 3'($urandom); in_rd = 5'($urandom);
    check("busy_in_ready", 64'(in_ready), 64'd0);

    if (req) begin
      for (int i = 0; i < req_stall; i++) begin
        check("req_valid_stall", 64'(rreq_valid), 64'd1);
        check("req_addr_stall", rreq_addr, exp_a);
        check("req_out_valid", 64'(out_valid), 64'd0);
        rresp_valid = (i == 1);
        rresp_data  = {$urandom, $urandom};
        rresp_err   = 1'($urandom);
        @(posedge clk); #1;
      end
      rresp_valid = 1'b0; rresp_err = 1'b0;
      check("req_valid", 64'(rreq_valid), 64'd1);
      check("req_addr", rreq_addr, exp_a);
      rreq_ready = 1'b1;
      @(posedge clk); #1;
      rreq_ready = 1'b0;
      check("wait_req_valid", 64'(rreq_valid), 64'd0);
      for (int i = 0; i < wait_cyc; i++) begin
        check("wait_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
      end
      rresp_valid = 1'b1; rresp_data = data; rresp_err = err;
      @(posedge clk); #1;
      rresp_valid = 1'b0; rresp_err = 1'b0; rresp_data = {$urandom, $urandom};
    end else begin
      check("noreq_req_valid", 64'(rreq_valid), 64'd0);
    end

    for (int i = 0; i <= out_stall; i++) begin
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", out_data, exp_d);
      check("out_rd", 64'(out_rd), 64'(rd));
      check("out_fault", 64'(out_fault), 64'(exp_f));
      check("done_in_ready", 64'(in_ready), 64'd0);
      check("done_req_valid", 64'(rreq_valid), 64'd0);
      out_ready = (i == out_stall);
      @(posedge clk); #1;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check("ret_out_valid", 64'(out_valid), 64'd0);
    check("ret_in_ready", 64'(in_ready), 64'd1);
    check("ret_req_valid", 64'(rreq_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_memrop = '0; in_rd = '0;
    rreq_ready = 1'b0; rresp_valid = 1'b0; rresp_data = '0; rresp_err = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_req_valid", 64'(rreq_valid), 64'd0);
    check("rst_req_addr", rreq_addr, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_fault", 64'(out_fault), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through, byte and word lanes with known results.
    do_op(64'h1234, 3'd0, 5'd5, 64'd0, 1'b0, 0, 0, 0, 1'b1, 64'h1234);
    do_op(64'h8000_0003, 3'd1, 5'd1, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0,
          1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(64'h8000_0003, 3'd5, 5'd2, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0,
          1'b1, 64'h80);
    do_op(64'h8000_0004, 3'd3, 5'd3, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 0,
          1'b1, 64'hFFFF_FFFF_8765_4321);
    do_op(64'h8000_0004, 3'd7, 5'd4, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 0,
          1'b1, 64'h0000_0000_8765_4321);
    // Misaligned half: fault or natural alignment, depending on build.
    do_op(64'h8000_0001, 3'd2, 5'd6, 64'h1122_3344_5566_F788, 1'b0, 0, 0, 0, 1'b0, 64'd0);
    // Bus and writeback backpressure with a spurious response during REQ.
    do_op(64'h8000_0016, 3'd6, 5'd7, 64'hA5A5_1234_5678_9ABC, 1'b0, 4, 2, 3, 1'b0, 64'd0);
    // Bus error on a dword load.
    do_op(64'h8000_0008, 3'd4, 5'd8, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1, 0, 1, 1'b0, 64'd0);

    // Reset while waiting for the response; the pending response must be ignored.
    in_valid = 1'b1; in_addr = 64'h8000_0010; in_memrop = 3'd4; in_rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; rreq_ready = 1'b1;
    @(posedge clk); #1;
    rreq_ready = 1'b0; rresp_valid = 1'b1; rresp_data = 64'h0123_4567_89AB_CDEF;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_req_valid", 64'(rreq_valid), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_out_rd", 64'(out_rd), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_req_valid", 64'(rreq_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    rresp_valid = 1'b0;

    // Randomized ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      a = {32'h0000_0000, 32'h8000_0000 | 32'($urandom_range(0, 4095))};
      d = {$urandom, $urandom};
      do_op(a, 3'($urandom), 5'($urandom), d, ($urandom_range(0, 7) == 0),
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
